// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial LSB-first subtractor with valid/ready handshake
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_sh;
  logic [WIDTH-1:0] d_nx;
  logic             br;
  logic             br_nx;
  logic             d_bit;
  logic             last;
  logic [CW-1:0]    cnt;

  // Full-subtractor cell on the current LSBs; d_nx is the working
  // difference after this bit lands in the MSB.
  assign d_bit = a_sh[0] ^ b_sh[0] ^ br;
  assign br_nx = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
  assign d_nx  = (d_sh >> 1) | ({{(WIDTH-1){1'b0}}, d_bit} << (WIDTH - 1));
  assign last  = (cnt == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: operands load on accept, one bit per SHIFT edge; the visible
  // result registers only update on the final bit so they stay stable
  // while the next operation is in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      d_sh <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh <= a;
            b_sh <= b;
            d_sh <= '0;
            br   <= 1'b0;
            cnt  <= '0;
          end
        end
        SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          d_sh <= d_nx;
          br   <= br_nx;
          cnt  <= cnt + CW'(1);
          if (last) begin
            diff <= d_nx;
            bout <= br_nx;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - directed and random checks for serial_sub
module tb_serial_sub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv8, or8;
  logic [7:0]  a8, b8;
  logic        ir8, ov8, bo8, bz8;
  logic [7:0]  d8;
  logic        iv16, or16;
  logic [15:0] a16, b16;
  logic        ir16, ov16, bo16, bz16;
  logic [15:0] d16;

  int passed = 0;
  int total  = 0;

  serial_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .diff(d8), .bout(bo8), .busy(bz8)
  );

  serial_sub #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .out_valid(ov16), .out_ready(or16), .diff(d16), .bout(bo16), .busy(bz16)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair on the 8-bit DUT and return edges to out_valid.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, output int lat);
    int w = 0;
    while (!ir8 && w < 50) begin step(); w++; end
    a8 = a; b8 = b; iv8 = 1'b1;
    step();
    iv8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 100) begin step(); lat++; end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; iv8 = 1'b1; or8 = 1'b0; a8 = 8'h12; b8 = 8'h34;
    iv16 = 1'b0; or16 = 1'b0; a16 = '0; b16 = '0;
    step(); step();
    rst_n = 1'b1; iv8 = 1'b0;
    total++;
    if ({ir8, ov8, bz8, bo8, d8} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00})
      $display("FAIL reset8: ir/ov/busy/bout/diff=%b%b%b%b/%h required 1000/00", ir8, ov8, bz8, bo8, d8);
    else passed++;
    total++;
    if ({ir16, ov16, bz16, bo16, d16} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000})
      $display("FAIL reset16: ir/ov/busy/bout/diff=%b%b%b%b/%h required 1000/0000", ir16, ov16, bz16, bo16, d16);
    else passed++;
  endtask

  task automatic test_basic;
    int lat;
    or8 = 1'b1;
    run_op8(8'h05, 8'h03, lat);
    total++;
    if (lat !== 8) $display("FAIL basic_latency: got %0d required 8", lat); else passed++;
    total++;
    if ({d8, bo8} !== {8'h02, 1'b0})
      $display("FAIL basic_result: diff=%h bout=%b required 02/0", d8, bo8);
    else passed++;
    total++;
    if (bz8 !== 1'b1 || ir8 !== 1'b0)
      $display("FAIL basic_done_flags: busy=%b in_ready=%b required 1/0", bz8, ir8);
    else passed++;
    step();
    total++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1)
      $display("FAIL basic_one_cycle: out_valid=%b in_ready=%b required 0/1", ov8, ir8);
    else passed++;
  endtask

  task automatic test_vectors;
    logic [7:0] va [3] = '{8'h03, 8'h00, 8'hFF};
    logic [7:0] vb [3] = '{8'h05, 8'h01, 8'hFF};
    logic [7:0] vd [3] = '{8'hFE, 8'hFF, 8'h00};
    logic       vo [3] = '{1'b1, 1'b1, 1'b0};
    int lat;
    or8 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_op8(va[i], vb[i], lat);
      total++;
      if ({d8, bo8} !== {vd[i], vo[i]} || lat !== 8)
        $display("FAIL vector%0d: diff=%h bout=%b lat=%0d required %h/%b/8", i, d8, bo8, lat, vd[i], vo[i]);
      else passed++;
      step();
    end
  endtask

  task automatic test_backpressure;
    int lat;
    int bad = 0;
    or8 = 1'b0;
    run_op8(8'h80, 8'h01, lat);
    for (int i = 0; i < 5; i++) begin
      step();
      if (d8 !== 8'h7F || bo8 !== 1'b0 || ir8 !== 1'b0 || ov8 !== 1'b1) bad++;
    end
    total++;
    if (bad !== 0 || lat !== 8)
      $display("FAIL backpressure_hold: %0d unstable cycles lat=%0d diff=%h required 0 unstable lat 8 diff 7f", bad, lat, d8);
    else passed++;
    or8 = 1'b1;
    step();
    total++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0)
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b required 1/0", ir8, ov8);
    else passed++;
  endtask

  task automatic test_busy_ignore;
    int lat = 0;
    int extra = 0;
    or8 = 1'b1;
    a8 = 8'h10; b8 = 8'h01; iv8 = 1'b1;
    step();
    iv8 = 1'b0;
    step(); step(); lat = 2;
    a8 = 8'hAA; b8 = 8'h55; iv8 = 1'b1;
    for (int i = 0; i < 4; i++) begin step(); lat++; end
    iv8 = 1'b0;
    while (!ov8 && lat < 100) begin step(); lat++; end
    total++;
    if ({d8, bo8} !== {8'h0F, 1'b0} || lat !== 8)
      $display("FAIL busy_ignore_result: diff=%h bout=%b lat=%0d required 0f/0/8", d8, bo8, lat);
    else passed++;
    for (int i = 0; i < 20; i++) begin step(); if (ov8) extra++; end
    total++;
    if (extra !== 0) $display("FAIL busy_ignore_second: %0d extra out_valid cycles required 0", extra);
    else passed++;
  endtask

  task automatic test_mid_reset;
    int lat;
    int extra = 0;
    or8 = 1'b1;
    a8 = 8'h33; b8 = 8'h11; iv8 = 1'b1;
    step();
    iv8 = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    total++;
    if ({ir8, ov8, bz8, d8, bo8} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0})
      $display("FAIL mid_reset_state: ir/ov/busy=%b%b%b diff=%h bout=%b required 100/00/0", ir8, ov8, bz8, d8, bo8);
    else passed++;
    for (int i = 0; i < 15; i++) begin step(); if (ov8) extra++; end
    total++;
    if (extra !== 0) $display("FAIL mid_reset_abort: %0d out_valid cycles required 0", extra);
    else passed++;
    run_op8(8'h09, 8'h04, lat);
    total++;
    if ({d8, bo8} !== {8'h05, 1'b0} || lat !== 8)
      $display("FAIL mid_reset_fresh: diff=%h bout=%b lat=%0d required 05/0/8", d8, bo8, lat);
    else passed++;
    step();
  endtask

  task automatic test_back_to_back;
    int cyc = 0;
    int first = -1;
    int second = -1;
    or8 = 1'b1;
    a8 = 8'h07; b8 = 8'h02; iv8 = 1'b1;
    while (second < 0 && cyc < 100) begin
      step(); cyc++;
      if (ov8) begin
        if (first < 0) first = cyc;
        else begin second = cyc; iv8 = 1'b0; end
      end
    end
    iv8 = 1'b0;
    total++;
    if (second - first !== 10 || d8 !== 8'h05)
      $display("FAIL back_to_back_spacing: got %0d cycles diff=%h required 10 cycles diff 05", second - first, d8);
    else passed++;
    step();
  endtask

  task automatic test_random(input bit w16);
    logic [31:0] mask, ra, rb, ed;
    logic        eb, cur_ov, cur_ir, cur_bo, orv;
    logic [31:0] cur_d, cap_d;
    int lat, w, bad = 0;
    mask = w16 ? 32'h0000_FFFF : 32'h0000_00FF;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom & mask;
      rb = $urandom & mask;
      ed = (ra - rb) & mask;
      eb = (ra < rb);
      w = 0;
      cur_ir = w16 ? ir16 : ir8;
      while (!cur_ir && w < 50) begin step(); w++; cur_ir = w16 ? ir16 : ir8; end
      if (w16) begin a16 = ra[15:0]; b16 = rb[15:0]; iv16 = 1'b1; end
      else begin a8 = ra[7:0]; b8 = rb[7:0]; iv8 = 1'b1; end
      step();
      iv16 = 1'b0; iv8 = 1'b0;
      lat = 0;
      cur_ov = w16 ? ov16 : ov8;
      while (!cur_ov && lat < 100) begin step(); lat++; cur_ov = w16 ? ov16 : ov8; end
      cur_d  = w16 ? {16'h0, d16} : {24'h0, d8};
      cur_bo = w16 ? bo16 : bo8;
      cap_d  = cur_d;
      if (cur_d !== ed || cur_bo !== eb || lat !== (w16 ? 16 : 8)) begin
        bad++;
        if (bad < 5)
          $display("FAIL random_w%0d: a=%h b=%h diff=%h bout=%b lat=%0d required %h/%b", w16 ? 16 : 8, ra, rb, cur_d, cur_bo, lat, ed, eb);
      end
      w = 0;
      orv = 1'b0;
      while (!orv && w < 20) begin
        orv = 1'($urandom_range(0, 1));
        or16 = orv; or8 = orv;
        step(); w++;
        cur_d = w16 ? {16'h0, d16} : {24'h0, d8};
        if (!orv && cur_d !== cap_d) bad++;
      end
      if (!orv) begin or16 = 1'b1; or8 = 1'b1; step(); end
    end
    total++;
    if (bad !== 0) $display("FAIL random_w%0d_total: %0d bad results required 0", w16 ? 16 : 8, bad);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_backpressure();
    test_busy_ignore();
    test_mid_reset();
    test_back_to_back();
    test_random(1'b0);
    test_random(1'b1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  operand pair a/b is presented.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a  input  WIDTH  minuend.
REQ-007 b  input  WIDTH  subtrahend.
REQ-008 out_valid  output  1  diff/bout hold a completed result.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 diff  output  WIDTH  difference, (a - b) mod 2^WIDTH.
REQ-011 bout  output  1  final borrow; 1 iff a < b, unsigned.
REQ-012 busy  output  1  high in SHIFT and DONE states.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 Accept: in IDLE with in_valid=1 at a rising edge, the block SHALL register a and b, clear the borrow register and bit counter, and enter SHIFT.
REQ-016 in_valid while not in IDLE SHALL be ignored; no operand is latched and no state changes.
REQ-017 Each SHIFT edge SHALL process one bit, LSB first, using a full-subtractor cell: d = a0 ^ b0 ^ br; br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
REQ-018 On each SHIFT edge, the shift registers SHALL do the following:
- the a and b registers shift right by one;
- d shifts into the MSB of the diff register;
- the counter increments.
REQ-019 After the WIDTH-th SHIFT edge, the FSM SHALL enter DONE, with diff holding the full result and bout equal to the final br.
REQ-020 Latency SHALL be exactly WIDTH clock edges from the accepting edge to the first cycle with out_valid=1.
REQ-021 In DONE, diff and bout SHALL be held stable until out_ready=1 is sampled at a rising edge; the FSM then returns to IDLE.
REQ-022 With out_ready tied high, out_valid SHALL be high for exactly one cycle, and in_ready SHALL rise on the following cycle.
REQ-023 In IDLE and SHIFT, diff and bout SHALL retain their previous values; the interface is qualified only by out_valid.
REQ-024 Throughput SHALL be one operation per WIDTH+2 cycles at best; there SHALL be no overlap between operations.
REQ-025 The counter width SHALL be clog2(WIDTH+1); no other wrap-around behaviour is permitted.

Reset
REQ-026 While rst_n=0 at a rising edge, the block SHALL set the following, regardless of in_valid/out_ready:
- state = IDLE;
- diff = 0, bout = 0;
- the borrow register, counter and operand registers = 0;
- out_valid = 0, busy = 0, in_ready = 1.
REQ-027 Reset asserted mid-SHIFT or in DONE SHALL abort the operation; no out_valid SHALL follow for the aborted operands.
REQ-028 Reset is synchronous only; rst_n changes between edges SHALL have no effect on outputs.

Verification
REQ-029 WIDTH=8: accept a=0x05, b=0x03, out_ready=1 -> out_valid exactly 8 cycles after accept, diff=0x02, bout=0.
REQ-030 WIDTH=8: a=0x03, b=0x05 -> diff=0xFE, bout=1; a=0x00, b=0x01 -> diff=0xFF, bout=1; a=0xFF, b=0xFF -> diff=0x00, bout=0.
REQ-031 Backpressure: a=0x80, b=0x01, out_ready=0 for 5 cycles after out_valid -> diff=0x7F and bout=0 stay stable, in_ready=0 throughout; out_ready=1 -> IDLE on next edge.
REQ-032 Busy-ignore: assert in_valid with a=0xAA, b=0x55 during SHIFT of an operation on 0x10-0x01 -> result 0x0F, bout=0, no second result.
REQ-033 Mid-operation reset: rst_n=0 for one edge at SHIFT bit 4 -> next cycle in_ready=1, out_valid=0, diff=0; a fresh operation 0x09-0x04 then yields 0x05.
REQ-034 Random: 1000 random pairs at WIDTH=8 and WIDTH=16 with random out_ready -> every result matches the (a-b) mod 2^WIDTH and a<b reference model, and latency is WIDTH.
